sme_cmd_feeder: RTL

SME_CMD_FEEDER -- requirements
Module: sme_cmd_feeder

---
 rtl/sme_cmd_feeder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sme_cmd_feeder.sv
// Line-oriented command feeder: buffers one 'S'/'P' line from a byte stream and
// replays its payload to the SME matcher, waiting for the match result after patterns.
module sme_cmd_feeder #(
  parameter int MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  output logic       busy,
  output logic       err,
  output logic [7:0] pat_count
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_EMIT = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  logic [2:0]    state, state_n;
  logic [LW-1:0] len, k;
  logic          is_s;
  logic          xfer;
  logic [7:0]    mem [MAX_LEN];

  assign xfer = in_valid && in_ready;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (xfer) begin
        if (in_data == CH_S || in_data == CH_P) state_n = ST_LOAD;
        else if (in_data != CH_LF)              state_n = ST_DROP;
      end
      ST_LOAD: if (xfer && in_data != CH_CR) begin
        if (in_data == CH_LF)                   state_n = (len == '0) ? ST_IDLE : ST_EMIT;
        else if (len == LW'(MAX_LEN))           state_n = ST_DROP;
      end
      ST_EMIT: if (k == len)                    state_n = is_s ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (sme_valid)                   state_n = ST_IDLE;
      ST_DROP: if (xfer && in_data == CH_LF)    state_n = ST_IDLE;
      default:                                  state_n = ST_IDLE;
    endcase
  end

  // in_ready and busy are registered from the next state so they change together with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      chardata  <= '0;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      err       <= 1'b0;
      pat_count <= '0;
      len       <= '0;
      k         <= '0;
      is_s      <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n != ST_EMIT) && (state_n != ST_WAIT);
      busy     <= (state_n != ST_IDLE);
      err      <= 1'b0;
      case (state)
        ST_IDLE: if (xfer) begin
          if (in_data == CH_S || in_data == CH_P) begin
            is_s <= (in_data == CH_S);
            len  <= '0;
          end else if (in_data != CH_LF) begin
            err <= 1'b1;
          end
        end
        ST_LOAD: if (xfer && in_data != CH_CR) begin
          if (in_data == CH_LF) begin
            if (len == '0) err <= 1'b1;
            k <= '0;
          end else if (len == LW'(MAX_LEN)) begin
            err <= 1'b1;
          end else begin
            len <= len + 1'b1;
          end
        end
        ST_EMIT: begin
          if (k == len) begin
            isstring  <= 1'b0;
            ispattern <= 1'b0;
          end else begin
            chardata  <= mem[k[IW-1:0]];
            isstring  <= is_s;
            ispattern <= !is_s;
            k         <= k + 1'b1;
          end
        end
        ST_WAIT: if (sme_valid) pat_count <= pat_count + 8'd1;
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; entries are only read after being written for this line.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && xfer && in_data != CH_LF && in_data != CH_CR
        && len != LW'(MAX_LEN))
      mem[len[IW-1:0]] <= in_data;
  end

endmodule
